// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use and branch interlocks, E/D-stage forwarding,
// and a RUN / MEM_WAIT / MUL_BUSY sequencer for long-latency memory and multiply.
module pipe_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RFAE,
  input  logic [4:0]  RFAM,
  input  logic [4:0]  RFAW,
  input  logic        RFWEE,
  input  logic        RFWEM,
  input  logic        RFWEW,
  input  logic        MtoRFSelE,
  input  logic        MtoRFSelM,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic        DMReqM,
  input  logic        DMRdy,
  input  logic        MulStartE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic [1:0]  FwdAE,
  output logic [1:0]  FwdBE,
  output logic        FwdAD,
  output logic        FwdBD,
  output logic        Busy,
  output logic [15:0] StallCnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_BUSY = 2'd2
  } state_t;

  // Counter is loaded so that it reaches zero on the last stall cycle.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

  state_t      state;
  logic [3:0]  mul_cnt;
  logic [15:0] stall_cnt;
  logic        load_use;
  logic        branch_stall;
  logic        hazard;

  function automatic logic src_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic wem, input logic [4:0] dstm,
                                         input logic wew, input logic [4:0] dstw,
                                         input logic [4:0] src);
    if (src_hit(wem, dstm, src)) begin
      return 2'b10;
    end else if (src_hit(wew, dstw, src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign load_use = MtoRFSelE && (src_hit(RFWEE, RFAE, RsD) || src_hit(RFWEE, RFAE, RtD));
  assign branch_stall = BranchD &&
      (src_hit(RFWEE, RFAE, RsD) || src_hit(RFWEE, RFAE, RtD) ||
       (MtoRFSelM && (src_hit(RFWEM, RFAM, RsD) || src_hit(RFWEM, RFAM, RtD))));
  assign hazard   = load_use || branch_stall;
  assign StallCnt = stall_cnt;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    FwdAE  = fwd_sel(RFWEM, RFAM, RFWEW, RFAW, RsE);
    FwdBE  = fwd_sel(RFWEM, RFAM, RFWEW, RFAW, RtE);
    FwdAD  = src_hit(RFWEM, RFAM, RsD);
    FwdBD  = src_hit(RFWEM, RFAM, RtD);
    Busy   = (state != RUN);
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
      FwdAE  = 2'b00;
      FwdBE  = 2'b00;
      FwdAD  = 1'b0;
      FwdBD  = 1'b0;
      Busy   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          StallF = hazard;
          StallD = hazard;
          FlushE = hazard;
          FlushD = PCSrcD && !hazard;
        end
        MEM_WAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end
        MUL_BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end
        default: begin
          StallF = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mul_cnt   <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (StallF && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      case (state)
        RUN: begin
          if (DMReqM && !DMRdy) begin
            state <= MEM_WAIT;
          end else if (MulStartE) begin
            state   <= MUL_BUSY;
            mul_cnt <= MUL_LOAD;
          end
        end
        MEM_WAIT: begin
          if (DMRdy) begin
            state <= RUN;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt == 4'd0) begin
            state <= RUN;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: begin
          state   <= RUN;
          mul_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked each cycle
// against a stage-occupancy model of the controller.
module tb_pipe_ctrl;
  localparam int MC = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] RsD, RtD, RsE, RtE, RFAE, RFAM, RFAW;
  logic RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, PCSrcD, DMReqM, DMRdy, MulStartE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, FwdAD, FwdBD, Busy;
  logic [1:0] FwdAE, FwdBE;
  logic [15:0] StallCnt;

  int checks = 0;
  int errors = 0;

  // model: mode 0 = running, 1 = waiting on memory, 2 = multiply with rem stall cycles left
  int m_mode = 0;
  int m_rem = 0;
  int m_cnt = 0;
  bit e_stallf;

  pipe_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .RFAE(RFAE), .RFAM(RFAM), .RFAW(RFAW), .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
    .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .DMReqM(DMReqM), .DMRdy(DMRdy), .MulStartE(MulStartE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .FwdAE(FwdAE), .FwdBE(FwdBE), .FwdAD(FwdAD), .FwdBD(FwdBD),
    .Busy(Busy), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // forwarding source: scan producers youngest first, first writer of src wins
  function automatic int fwd_code(input logic [4:0] src);
    logic [4:0] dst [2];
    logic       we  [2];
    dst[0] = RFAM; we[0] = RFWEM;
    dst[1] = RFAW; we[1] = RFWEW;
    for (int i = 0; i < 2; i++) begin
      if (we[i] && dst[i] != 5'd0 && dst[i] == src) return 2 - i;
    end
    return 0;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return r != 5'd0 && (r == RsD || r == RtD);
  endfunction

  task automatic settle();
    bit hz;
    int sf, sd, se, sm, fd, fe, fm, fw, fae, fbe, fad, fbd, bz;
    #2;
    hz = (MtoRFSelE && RFWEE && reads(RFAE)) ||
         (BranchD && ((RFWEE && reads(RFAE)) || (MtoRFSelM && RFWEM && reads(RFAM))));
    fae = fwd_code(RsE);
    fbe = fwd_code(RtE);
    fad = (RFWEM && RFAM != 5'd0 && RFAM == RsD);
    fbd = (RFWEM && RFAM != 5'd0 && RFAM == RtD);
    bz = (m_mode != 0);
    {sf, sd, se, sm, fd, fe, fm, fw} = '0;
    if (rst) begin
      {fd, fe, fm, fw} = {1, 1, 1, 1};
      {fae, fbe, fad, fbd, bz} = '0;
    end else if (m_mode == 1) begin
      {sf, sd, se, sm, fw} = {1, 1, 1, 1, 1};
    end else if (m_mode == 2) begin
      {sf, sd, se, fm} = {1, 1, 1, 1};
    end else begin
      sf = hz; sd = hz; fe = hz;
      fd = PCSrcD && !hz;
    end
    e_stallf = (sf != 0);
    chk("StallF", StallF, sf); chk("StallD", StallD, sd);
    chk("StallE", StallE, se); chk("StallM", StallM, sm);
    chk("FlushD", FlushD, fd); chk("FlushE", FlushE, fe);
    chk("FlushM", FlushM, fm); chk("FlushW", FlushW, fw);
    chk("FwdAE", FwdAE, fae); chk("FwdBE", FwdBE, fbe);
    chk("FwdAD", FwdAD, fad); chk("FwdBD", FwdBD, fbd);
    chk("Busy", Busy, bz); chk("StallCnt", StallCnt, m_cnt);
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_rem = 0; m_cnt = 0;
    end else begin
      if (e_stallf && m_cnt < 65535) m_cnt++;
      if (m_mode == 0) begin
        if (DMReqM && !DMRdy) m_mode = 1;
        else if (MulStartE) begin m_mode = 2; m_rem = MC - 1; end
      end else if (m_mode == 1) begin
        if (DMRdy) m_mode = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic clear();
    {RsD, RtD, RsE, RtE, RFAE, RFAM, RFAW} = '0;
    {RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, PCSrcD, DMReqM, MulStartE} = '0;
    DMRdy = 1'b1;
  endtask

  task automatic do_reset();
    clear();
    rst = 1'b1;
    settle();
    chk("rst_flushd_lit", FlushD, 1);
    chk("rst_stallf_lit", StallF, 0);
    adv();
    rst = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    rst = 1'b1;
    clear();
    @(negedge clk);
    do_reset();

    // load-use
    MtoRFSelE = 1'b1; RFWEE = 1'b1; RFAE = 5'd8; RsD = 5'd8;
    settle();
    chk("lu_stallf_lit", StallF, 1); chk("lu_stalld_lit", StallD, 1); chk("lu_flushe_lit", FlushE, 1);
    adv();
    clear();
    settle();
    chk("lu_stallf_after_lit", StallF, 0); chk("lu_cnt_lit", StallCnt, 1);
    adv();

    // forwarding priority
    RFAM = 5'd5; RFAW = 5'd5; RsE = 5'd5; RFWEM = 1'b1; RFWEW = 1'b1;
    settle(); chk("fwd_m_lit", FwdAE, 2); adv();
    RFWEM = 1'b0;
    settle(); chk("fwd_w_lit", FwdAE, 1); adv();
    RsE = 5'd0;
    settle(); chk("fwd_r0_lit", FwdAE, 0); adv();

    // memory wait
    do_reset();
    DMReqM = 1'b1; DMRdy = 1'b0;
    settle(); chk("mem_busy0_lit", Busy, 0); adv();
    for (int i = 0; i < 2; i++) begin
      settle(); chk("mem_busy_lit", Busy, 1); chk("mem_stallm_lit", StallM, 1); adv();
    end
    DMRdy = 1'b1;
    settle(); chk("mem_flushw_lit", FlushW, 1); adv();
    clear();
    settle(); chk("mem_run_lit", Busy, 0); chk("mem_cnt_lit", StallCnt, 3); adv();

    // multiply, then multiply colliding with a memory miss
    do_reset();
    MulStartE = 1'b1;
    step();
    MulStartE = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (StallE && FlushM && Busy) busy_cycles++;
      adv();
    end
    chk("mul_len_lit", busy_cycles, 3);
    MulStartE = 1'b1; DMReqM = 1'b1; DMRdy = 1'b0;
    step();
    MulStartE = 1'b0;
    settle(); chk("mul_vs_mem_stallm_lit", StallM, 1); chk("mul_vs_mem_flushm_lit", FlushM, 0); adv();
    DMRdy = 1'b1;
    step();
    clear();

    // branch hazard then taken branch without hazard
    do_reset();
    BranchD = 1'b1; RFAE = 5'd3; RsD = 5'd3; RFWEE = 1'b1; PCSrcD = 1'b1;
    settle(); chk("br_stall_lit", StallF, 1); chk("br_flushd_lit", FlushD, 0); adv();
    clear();
    PCSrcD = 1'b1;
    settle(); chk("br_taken_flushd_lit", FlushD, 1); adv();

    // reset in the middle of a multiply
    clear();
    MulStartE = 1'b1;
    step();
    clear();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle(); chk("rst_mul_busy_lit", Busy, 0); chk("rst_mul_cnt_lit", StallCnt, 0); adv();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      RsE       = 5'($urandom_range(0, 3));
      RtE       = 5'($urandom_range(0, 3));
      RFAE      = 5'($urandom_range(0, 3));
      RFAM      = 5'($urandom_range(0, 3));
      RFAW      = 5'($urandom_range(0, 3));
      RFWEE     = 1'($urandom_range(0, 1));
      RFWEM     = 1'($urandom_range(0, 1));
      RFWEW     = 1'($urandom_range(0, 1));
      MtoRFSelE = 1'($urandom_range(0, 1));
      MtoRFSelM = 1'($urandom_range(0, 1));
      BranchD   = 1'($urandom_range(0, 1));
      PCSrcD    = 1'($urandom_range(0, 1));
      DMReqM    = ($urandom_range(0, 3) == 0);
      DMRdy     = ($urandom_range(0, 2) != 0);
      MulStartE = ($urandom_range(0, 15) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
